writeback_regfile: RTL and testbench

//  Writeback stage and architectural register file, directly downstream of the ALU.

---
 rtl/writeback_regfile.sv | 133 +++++++++++++
 tb/tb_writeback_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage and 16-entry register file, two async read ports
// Optional REGFILE_BYPASS_EN: forward the in-flight write data to the read ports.
module writeback_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_wide,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic              wb_zero,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              zero_flag
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] hi_data;
  logic [ADDR_W-1:0] hi_addr;

  logic              accept;
  logic [ADDR_W-1:0] rd_plus1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign wb_ready = (state == ST_IDLE);
  assign accept   = wb_valid & wb_ready;
  assign rd_plus1 = wb_rd + ADDR_W'(1);

  // Single write port: the pending high word owns it in HI, the accepted low word otherwise.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wb_rd;
    wr_data = wb_lo;
    if (state == ST_HI) begin
      wr_en   = 1'b1;
      wr_addr = hi_addr;
      wr_data = hi_data;
    end else if (accept) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hi_data   <= '0;
      hi_addr   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (wb_wide) begin
              hi_data   <= wb_hi;
              hi_addr   <= rd_plus1;
              zero_flag <= wb_zero & (wb_hi == '0);
              state     <= ST_HI;
            end else begin
              zero_flag <= wb_zero;
            end
          end
        end
        ST_HI: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_lo;
  logic fwd_hi_now;

  // Reset holds every read at the array value (zero), even with a result on the inputs.
  assign fwd_lo     = accept & ~rst;
  assign fwd_hi_now = accept & ~rst & wb_wide;

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (state == ST_HI && rs1_addr == hi_addr) begin
      rs1_data = hi_data;
    end else if (fwd_lo && rs1_addr == wb_rd) begin
      rs1_data = wb_lo;
    end else if (fwd_hi_now && rs1_addr == rd_plus1) begin
      rs1_data = wb_hi;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (state == ST_HI && rs2_addr == hi_addr) begin
      rs2_data = hi_data;
    end else if (fwd_lo && rs2_addr == wb_rd) begin
      rs2_data = wb_lo;
    end else if (fwd_hi_now && rs2_addr == rd_plus1) begin
      rs2_data = wb_hi;
    end
  end
`else
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed plus random checks of writeback_regfile against a behavioural model
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic        wb_wide;
  logic [15:0] wb_lo;
  logic [15:0] wb_hi;
  logic        wb_zero;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        zero_flag;

  writeback_regfile #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_wide  (wb_wide),
    .wb_lo    (wb_lo),
    .wb_hi    (wb_hi),
    .wb_zero  (wb_zero),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  // Model: architectural registers, queue of high-word writes still owed, committed zero flag.
  logic [15:0] m_regs [16];
  wr_t         hi_q [$];
  logic        m_zero;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    hi_q.delete();
    m_zero = 1'b0;
  endtask

  function automatic logic exp_ready();
    return (hi_q.size() == 0);
  endfunction

  function automatic logic [15:0] exp_read(input logic [3:0] a);
    logic [3:0] nxt;
    nxt = wb_rd + 4'd1;
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (hi_q.size() != 0) begin
        if (hi_q[0].a == a) return hi_q[0].d;
      end else if (wb_valid) begin
        if (a == wb_rd) return wb_lo;
        if (wb_wide && a == nxt) return wb_hi;
      end
    end
`endif
    return m_regs[a];
  endfunction

  // Apply the architectural effect of one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] nxt;
    wr_t w;
    if (hi_q.size() != 0) begin
      m_regs[hi_q[0].a] = hi_q[0].d;
      void'(hi_q.pop_front());
    end else if (wb_valid) begin
      m_regs[wb_rd] = wb_lo;
      if (wb_wide) begin
        nxt = wb_rd + 4'd1;
        w.a = nxt;
        w.d = wb_hi;
        hi_q.push_back(w);
        m_zero = wb_zero && (wb_hi == 16'h0);
      end else begin
        m_zero = wb_zero;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] rd, input logic w,
                       input logic [15:0] lo, input logic [15:0] hi, input logic z,
                       input logic [3:0] a1, input logic [3:0] a2);
    wb_valid = v; wb_rd = rd; wb_wide = w; wb_lo = lo; wb_hi = hi; wb_zero = z;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    check("ready", 32'(wb_ready), 32'(exp_ready()));
    check("zero_flag", 32'(zero_flag), 32'(m_zero));
    check("rs1", 32'(rs1_data), 32'(exp_read(a1)));
    check("rs2", 32'(rs2_data), 32'(exp_read(a2)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 4'd0, 4'd1);
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [15:0] val);
    wb_valid = 1'b0;
    rs1_addr = a;
    rs2_addr = a;
    #1;
    check(tag, 32'(rs1_data), 32'(val));
    check(tag, 32'(rs2_data), 32'(val));
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = 4'd0; wb_wide = 1'b0; wb_lo = 16'h0; wb_hi = 16'h0; wb_zero = 1'b0;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-cycle clears written data immediately
    cycle(1'b1, 4'd3, 1'b0, 16'h1234, 16'h0, 1'b1, 4'd3, 4'd3);
    expect_reg("r3_written", 4'd3, 16'h1234);
    #2 rst = 1'b1;
    #1;
    check("rst_r3", 32'(rs1_data), 32'h0);
    check("rst_zero", 32'(zero_flag), 32'h0);
    check("rst_ready", 32'(wb_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Narrow writes and zero flag
    cycle(1'b1, 4'd5, 1'b0, 16'h00A5, 16'h0, 1'b0, 4'd5, 4'd0);
    idle();
    expect_reg("r5", 4'd5, 16'h00A5);
    check("narrow_zero0", 32'(zero_flag), 32'h0);
    check("narrow_ready", 32'(wb_ready), 32'h1);
    cycle(1'b1, 4'd6, 1'b0, 16'h0000, 16'h0, 1'b1, 4'd6, 4'd5);
    check("narrow_zero1", 32'(zero_flag), 32'h1);

    // Wide write, plain and wrapping
    cycle(1'b1, 4'd7, 1'b1, 16'h5678, 16'h1234, 1'b0, 4'd7, 4'd8);
    expect_reg("wide_r7", 4'd7, 16'h5678);
    check("wide_busy", 32'(wb_ready), 32'h0);
    idle();
    expect_reg("wide_r8", 4'd8, 16'h1234);
    check("wide_ready_back", 32'(wb_ready), 32'h1);
    cycle(1'b1, 4'd15, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 4'd15, 4'd0);
    idle();
    expect_reg("wrap_r15", 4'd15, 16'hAAAA);
    expect_reg("wrap_r0", 4'd0, 16'h5555);

    // Backpressure: narrow held through the HI cycle
    cycle(1'b1, 4'd10, 1'b1, 16'h0000, 16'h0001, 1'b1, 4'd10, 4'd11);
    check("wide_zero_hi", 32'(zero_flag), 32'h0);
    cycle(1'b1, 4'd9, 1'b0, 16'h0042, 16'h0, 1'b1, 4'd9, 4'd11);
    expect_reg("bp_r9_not_taken", 4'd9, 16'h0000);
    check("bp_zero_held", 32'(zero_flag), 32'h0);
    cycle(1'b1, 4'd9, 1'b0, 16'h0042, 16'h0, 1'b1, 4'd9, 4'd11);
    idle();
    expect_reg("bp_r9", 4'd9, 16'h0042);
    expect_reg("bp_r11", 4'd11, 16'h0001);
    check("bp_zero_taken", 32'(zero_flag), 32'h1);

    // Read of a register during its own write cycle
    cycle(1'b1, 4'd4, 1'b0, 16'h1111, 16'h0, 1'b0, 4'd4, 4'd4);
    cycle(1'b1, 4'd4, 1'b0, 16'hBEEF, 16'h0, 1'b0, 4'd4, 4'd5);
    idle();
    expect_reg("byp_r4", 4'd4, 16'hBEEF);

    // Abort pending high word with reset
    cycle(1'b1, 4'd2, 1'b1, 16'h7777, 16'hFFFF, 1'b0, 4'd3, 4'd2);
    rs1_addr = 4'd3;
    #2 rst = 1'b1;
    #1;
    check("abort_r3", 32'(rs1_data), 32'h0);
    check("abort_ready", 32'(wb_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    expect_reg("abort_r3_after", 4'd3, 16'h0000);
    expect_reg("abort_r2_after", 4'd2, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] hi_r;
      hi_r = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
            16'($urandom), hi_r, 1'($urandom), 4'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      idle();
      expect_reg("final_reg", 4'(i), m_regs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
